// File: rtl/echo_delay_line_if.sv
// echo_delay_line_if: frame strobe, stereo sample bus and status of the echo stage.
//   lrck       frame clock, rising edge starts a frame
//   sample_in  {left, right} signed 16-bit samples
//   enable     1 = mix echo, 0 = pass through
//   delay_len  echo delay in frames (0 acts as 1)
//   sample_out processed frame, valid while out_valid pulses
//   out_valid  one-cycle pulse on each new sample_out
//   busy       frame in flight
interface echo_delay_line_if #(parameter int ADDR_W = 12);
  logic              lrck;
  logic [31:0]       sample_in;
  logic              enable;
  logic [ADDR_W-1:0] delay_len;
  logic [31:0]       sample_out;
  logic              out_valid;
  logic              busy;
  modport master(output lrck, sample_in, enable, delay_len, input sample_out, out_valid, busy);
  modport slave(input lrck, sample_in, enable, delay_len, output sample_out, out_valid, busy);
endinterface

// File: rtl/echo_delay_line.sv
// echo_delay_line: per-frame stereo echo with a circular delay RAM and saturating mix.
//   clk  audio bit clock
//   rst  asynchronous active-high reset
//   io   echo_delay_line_if slave: lrck/sample_in/enable/delay_len in,
//        sample_out/out_valid/busy out
module echo_delay_line #(
  parameter int ADDR_W      = 12,
  parameter int ATTEN_SHIFT = 1,
  parameter int FEEDBACK    = 1
) (
  input  logic            clk,
  input  logic            rst,
  echo_delay_line_if.slave io
);
  typedef enum logic [1:0] {IDLE, READ, CALC, WRITE} state_t;
  state_t            state;
  logic              lrck_q;
  logic              strobe;
  logic [31:0]       in_reg;
  logic [31:0]       rd_data;
  logic [31:0]       delayed;
  logic [31:0]       mixed;
  logic [ADDR_W-1:0] d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;
  logic [31:0]       mem [2**ADDR_W];
  // 17-bit sum cannot overflow; saturate when the two top bits disagree
  function automatic logic [15:0] mix_ch(input logic [15:0] a, input logic [15:0] b);
    logic signed [16:0] s;
    s = $signed({a[15], a}) + ($signed({b[15], b}) >>> ATTEN_SHIFT);
    return (s[16] != s[15]) ? {s[16], {15{~s[16]}}} : s[15:0];
  endfunction
  assign strobe  = io.lrck & ~lrck_q;
  // fill gates out RAM words never written since reset
  assign delayed = (io.enable && fill >= d) ? rd_data : '0;
  assign mixed   = {mix_ch(in_reg[31:16], delayed[31:16]), mix_ch(in_reg[15:0], delayed[15:0])};
  // RAM is not reset; sample_out holds the mixed word during WRITE
  always_ff @(posedge clk) begin
    if (state == READ) rd_data <= mem[wr_ptr - d];
    if (state == WRITE) mem[wr_ptr] <= (FEEDBACK != 0) ? io.sample_out : in_reg;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lrck_q        <= 1'b0;
      in_reg        <= '0;
      d             <= ADDR_W'(1);
      wr_ptr        <= '0;
      fill          <= '0;
      io.sample_out <= '0;
      io.out_valid  <= 1'b0;
      io.busy       <= 1'b0;
    end else begin
      lrck_q       <= io.lrck;
      io.out_valid <= 1'b0;
      case (state)
        IDLE: if (strobe) begin
          in_reg  <= io.sample_in;
          d       <= (io.delay_len == '0) ? ADDR_W'(1) : io.delay_len;
          io.busy <= 1'b1;
          state   <= READ;
        end
        READ: state <= CALC;
        CALC: begin
          io.sample_out <= mixed;
          io.out_valid  <= 1'b1;
          state         <= WRITE;
        end
        WRITE: begin
          wr_ptr  <= wr_ptr + ADDR_W'(1);
          fill    <= (fill == '1) ? fill : fill + ADDR_W'(1);
          io.busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_echo_delay_line.sv
// tb_echo_delay_line: scoreboard bench for recirculating and single-echo variants of echo_delay_line.
module tb_echo_delay_line;
  typedef struct {logic [31:0] v; int c;} exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lrck = 1'b0;
  logic [31:0] sample_in = '0;
  logic        enable = 1'b1;
  logic [2:0]  delay_len = 3'd4;
  int          cyc = 0;
  int          asserts = 0;
  int          fails = 0;
  int          last_strobe = -100;
  int          k = 0;
  logic [31:0] hist[2][$];
  exp_t        q[2][$];
  logic [31:0] last_out[2];
  logic [31:0] so[2];
  logic        ov[2];
  logic        bz[2];
  echo_delay_line_if #(.ADDR_W(3)) if_fb();
  echo_delay_line_if #(.ADDR_W(3)) if_nf();
  assign if_fb.lrck = lrck;
  assign if_fb.sample_in = sample_in;
  assign if_fb.enable = enable;
  assign if_fb.delay_len = delay_len;
  assign if_nf.lrck = lrck;
  assign if_nf.sample_in = sample_in;
  assign if_nf.enable = enable;
  assign if_nf.delay_len = delay_len;
  assign so[0] = if_fb.sample_out;
  assign ov[0] = if_fb.out_valid;
  assign bz[0] = if_fb.busy;
  assign so[1] = if_nf.sample_out;
  assign ov[1] = if_nf.out_valid;
  assign bz[1] = if_nf.busy;
  echo_delay_line #(.ADDR_W(3), .ATTEN_SHIFT(1), .FEEDBACK(1)) u_fb (.clk(clk), .rst(rst), .io(if_fb.slave));
  echo_delay_line #(.ADDR_W(3), .ATTEN_SHIFT(1), .FEEDBACK(0)) u_nf (.clk(clk), .rst(rst), .io(if_nf.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] sat_mix(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + (int'($signed(b)) >>> 1);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction
  function automatic logic [31:0] mix_word(input logic [31:0] x, input logic [31:0] dl);
    return {sat_mix(x[31:16], dl[31:16]), sat_mix(x[15:0], dl[15:0])};
  endfunction
  // Reference: frame k echoes the word written at frame k-d, if that frame exists since reset
  task automatic frame(input logic [31:0] s);
    int dd;
    logic [31:0] m[2];
    dd = (delay_len == 0) ? 1 : int'(delay_len);
    for (int i = 0; i < 2; i++)
      m[i] = mix_word(s, (enable && k >= dd) ? hist[i][k-dd] : 32'h0);
    hist[0].push_back(m[0]);
    hist[1].push_back(s);
    k++;
    sample_in = s;
    @(negedge clk);
    lrck = 1'b1;
    last_strobe = cyc + 1;
    for (int i = 0; i < 2; i++) q[i].push_back('{m[i], cyc + 3});
    repeat (16) @(negedge clk);
    lrck = 1'b0;
    repeat (16) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    last_strobe = -100;
    k = 0;
    hist[0].delete();
    hist[1].delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic chk_idle(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_sample_out"}, so[i], 32'h0);
      chk({nm, "_out_valid"}, 32'(ov[i]), 32'h0);
      chk({nm, "_busy"}, 32'(bz[i]), 32'h0);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    for (int i = 0; i < 2; i++) begin
      chk(i ? "busy_nf" : "busy_fb", 32'(bz[i]), 32'(cyc >= last_strobe && cyc <= last_strobe + 2));
      if (q[i].size() != 0 && !ov[i] && cyc > q[i][0].c) begin
        chk(i ? "missing_valid_nf" : "missing_valid_fb", 32'(q[i][0].c), 32'(cyc));
        void'(q[i].pop_front());
      end
      if (ov[i]) begin
        last_out[i] = so[i];
        if (q[i].size() == 0) chk(i ? "unexpected_valid_nf" : "unexpected_valid_fb", 32'h1, 32'h0);
        else begin
          chk(i ? "latency_nf" : "latency_fb", 32'(cyc), 32'(q[i][0].c));
          chk(i ? "sample_out_nf" : "sample_out_fb", so[i], q[i][0].v);
          void'(q[i].pop_front());
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    frame(32'h1000F000);
    chk("pass_fb", last_out[0], 32'h1000F000);
    chk("pass_nf", last_out[1], 32'h1000F000);
    do_reset();
    for (int i = 0; i <= 12; i++) begin
      frame(i == 0 ? 32'h40000000 : 32'h0);
      if (i == 4) begin
        chk("echo4_fb", last_out[0], 32'h20000000);
        chk("echo4_nf", last_out[1], 32'h20000000);
      end
      if (i == 8) begin
        chk("echo8_fb", last_out[0], 32'h10000000);
        chk("echo8_nf", last_out[1], 32'h0);
      end
      if (i == 12) begin
        chk("echo12_fb", last_out[0], 32'h08000000);
        chk("echo12_nf", last_out[1], 32'h0);
      end
    end
    do_reset();
    delay_len = 3'd1;
    for (int i = 0; i < 5; i++) frame(32'h70007000);
    chk("sat_pos_fb", last_out[0], 32'h7FFF7FFF);
    chk("sat_pos_nf", last_out[1], 32'h7FFF7FFF);
    do_reset();
    for (int i = 0; i < 5; i++) frame(32'h90009000);
    chk("sat_neg_fb", last_out[0], 32'h80008000);
    chk("sat_neg_nf", last_out[1], 32'h80008000);
    do_reset();
    delay_len = 3'd7;
    for (int i = 0; i < 20; i++) begin
      frame(i == 0 ? 32'h20002000 : 32'h0);
      if (i == 6) chk("wrap_pre_fb", last_out[0], 32'h0);
      if (i == 7) begin
        chk("wrap7_fb", last_out[0], 32'h10001000);
        chk("wrap7_nf", last_out[1], 32'h10001000);
      end
      if (i == 14) chk("wrap14_fb", last_out[0], 32'h08000800);
    end
    do_reset();
    delay_len = 3'd0;
    frame(32'h40004000);
    frame(32'h0);
    chk("d0_fb", last_out[0], 32'h20002000);
    chk("d0_nf", last_out[1], 32'h20002000);
    enable = 1'b0;
    frame(32'h12345678);
    chk("bypass_fb", last_out[0], 32'h12345678);
    chk("bypass_nf", last_out[1], 32'h12345678);
    enable = 1'b1;
    do_reset();
    delay_len = 3'd2;
    sample_in = 32'h7FFF7FFF;
    @(negedge clk);
    lrck = 1'b1;
    last_strobe = cyc + 1;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    lrck = 1'b0;
    last_strobe = -100;
    #1;
    chk_idle("midop_reset");
    @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    frame(32'h40000000);
    frame(32'h0);
    chk("midop_f1_fb", last_out[0], 32'h0);
    frame(32'h0);
    chk("midop_f2_fb", last_out[0], 32'h20000000);
    chk("midop_f2_nf", last_out[1], 32'h20000000);
    do_reset();
    for (int i = 0; i < 80; i++) begin
      delay_len = 3'($urandom_range(0, 7));
      enable = ($urandom_range(0, 3) != 0);
      frame($urandom);
    end
    repeat (8) @(negedge clk);
    chk("drained_fb", 32'(q[0].size()), 32'h0);
    chk("drained_nf", 32'(q[1].size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/echo_delay_line.md
Name: echo_delay_line

Overview:
Per-frame echo stage between the ADC deserialiser and the DAC-side effect mux, clocked on the audio bit clock. On each left/right frame it reads a delayed stereo sample from a circular RAM, adds an attenuated copy to the live sample per channel with saturation, writes the result back, and presents it as the echo output word. The delay is runtime-selectable, and feedback mode is selectable by parameter.

Parameters:
ADDR_W, 12, delay RAM address width; depth = 2^ADDR_W stereo frames.
ATTEN_SHIFT, 1, arithmetic right shift applied to the delayed sample (gain 2^-ATTEN_SHIFT).
FEEDBACK, 1, 1 = write mixed output to RAM (recirculating echo); 0 = write raw input (single echo).

Ports:
clk  in  1  audio bit clock (AUD_BCLK domain).
rst  in  1  asynchronous reset, active-high.
lrck  in  1  frame clock (DACLRCK); a rising edge marks a new frame.
sample_in  in  32  {left[31:16], right[15:0]}, signed two's complement, stable around the lrck rise.
enable  in  1  1 = apply echo; 0 = pass through.
delay_len  in  ADDR_W  echo delay in frames; 0 is treated as 1.
sample_out  out  32  processed frame, same packing as sample_in.
out_valid  out  1  one-cycle pulse when sample_out updates.
busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1): sample_out=0, out_valid=0, busy=0, wr_ptr=0, fill=0, lrck_q=0, FSM=IDLE. RAM contents are not cleared.
- Edge detect: lrck_q <= lrck. strobe = lrck & ~lrck_q (cycle N).
- FSM states are IDLE, READ, CALC, WRITE.
  - IDLE: on strobe, capture sample_in -> in_reg, latch d = max(delay_len,1), go to READ.
  - READ: present rd_addr = (wr_ptr - d) mod 2^ADDR_W to the synchronous RAM (1-cycle read latency). Go to CALC.
  - CALC: RAM data is valid. If enable=1 and fill >= d, delayed = RAM data; otherwise delayed = 0. Per channel, sum17 = sext(in) + (delayed >>> ATTEN_SHIFT). Saturate sum17 to the range [-32768, 32767]. Go to WRITE.
  - WRITE: RAM[wr_ptr] <= (FEEDBACK ? mixed : in_reg). sample_out <= mixed and out_valid=1 for this cycle. wr_ptr++ (wraps modulo 2^ADDR_W). fill++ saturating at 2^ADDR_W-1. Return to IDLE.
- Latency: strobe at cycle N -> out_valid and sample_out update at cycle N+3. busy is high for cycles N+1..N+3.
- enable=0: sample_out = in_reg at the same latency. The RAM is still written (with in_reg), so history exists when enable goes high.
- A strobe while busy is ignored. Frames are at least 32 clk, so this does not occur in normal operation.
- delay_len changing mid-frame has no effect until the next strobe, because d is latched in IDLE.
- Wrap-around: rd_addr subtraction wraps modulo 2^ADDR_W. Maximum delay is 2^ADDR_W-1 frames.
- Reset mid-operation: immediate return to IDLE and the outputs above. fill=0 guarantees no stale RAM data is mixed until d new frames have been written.
- Attenuation shift is arithmetic (sign-preserving). Channels are processed independently with no cross-channel carry.

Test Plan:
1. Reset/pass: assert rst -> sample_out=0, out_valid=0, busy=0. Release, then with delay_len=4 apply a frame of 0x1000F000 -> sample_out=0x1000F000 at N+3 (fill<4); out_valid high for exactly 1 cycle.
2. Single echo (FEEDBACK=0, ATTEN_SHIFT=1, delay_len=4): left=0x4000 at frame 0, then zeros -> frame 4 left=0x2000; frames 8 and 12 left=0x0000; right=0 throughout.
3. Recirculating echo (FEEDBACK=1), same stimulus -> left=0x2000 at frame 4, 0x1000 at frame 8, 0x0800 at frame 12.
4. Saturation (delay_len=1): constant 0x70007000 -> from frame 1 onwards, output 0x7FFF7FFF. Constant 0x90009000 -> 0x80008000.
5. Wrap/limits (ADDR_W=3): delay_len=7 over 20 frames -> the echo appears exactly 7 frames after the impulse across the pointer wrap. delay_len=0 -> echo 1 frame later. Toggle enable=0 -> output equals input.
6. Reset mid-operation: pulse rst during CALC -> outputs 0 immediately, no out_valid. After release with delay_len=2, frames 0-1 show no echo and frame 2 shows the echo of frame 0.
